// File: rtl/ppu_bus_arbiter_if.sv
// Register-port bundle shared by the two requesters, the arbiter and the PPU.
// The arbiter uses the slave view; the environment (bridge, engine, PPU model) uses the master view.
interface ppu_bus_arbiter_if;
  logic       nmi;

  logic       r0_req;
  logic [2:0] r0_addr;
  logic       r0_wr;
  logic [7:0] r0_wdata;
  logic       r0_ack;
  logic [7:0] r0_rdata;

  logic       r1_req;
  logic [2:0] r1_addr;
  logic       r1_wr;
  logic [7:0] r1_wdata;
  logic       r1_ack;
  logic [7:0] r1_rdata;

  logic [2:0] ppu_addr;
  logic [7:0] ppu_wdata;
  logic [7:0] ppu_rdata;
  logic       ppu_rw;
  logic       ppu_cs;
  logic       vblank_win;

  modport slave (
    input  nmi,
    input  r0_req, r0_addr, r0_wr, r0_wdata,
    output r0_ack, r0_rdata,
    input  r1_req, r1_addr, r1_wr, r1_wdata,
    output r1_ack, r1_rdata,
    output ppu_addr, ppu_wdata, ppu_rw, ppu_cs, vblank_win,
    input  ppu_rdata
  );

  modport master (
    output nmi,
    output r0_req, r0_addr, r0_wr, r0_wdata,
    input  r0_ack, r0_rdata,
    output r1_req, r1_addr, r1_wr, r1_wdata,
    input  r1_ack, r1_rdata,
    input  ppu_addr, ppu_wdata, ppu_rw, ppu_cs, vblank_win,
    output ppu_rdata
  );
endinterface

// File: rtl/ppu_bus_arbiter.sv
// Shares the PPU CPU-side register port between the CPU bridge (port 0) and the
// sprite/scroll engine (port 1); port 1 is only served inside the NMI-opened vblank window.
module ppu_bus_arbiter #(
  parameter int GAP_CYCLES    = 1,
  parameter int VBLANK_CYCLES = 2273,
  parameter int R1_BURST      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ppu_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    GAP
  } state_t;

  localparam logic [11:0] VBLANK_LOAD = 12'(VBLANK_CYCLES);
  localparam logic [3:0]  GAP_LOAD    = 4'(GAP_CYCLES - 1);
  localparam logic [3:0]  BURST_MAX   = 4'(R1_BURST);

  state_t      state_q;
  logic        prev_nmi_q;
  logic [11:0] win_cnt_q;
  logic [11:0] win_cnt_d;
  logic        vblank_q;
  logic [3:0]  gap_cnt_q;
  logic [3:0]  burst_q;
  logic [3:0]  burst_d;
  logic        win_id_q;

  logic [2:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        rw_q;
  logic        cs_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [7:0]  rdata0_q;
  logic [7:0]  rdata1_q;

  logic        e0;
  logic        e1;
  logic        grant;
  logic        grant1;

  // A fresh NMI edge always restarts the window, even while it is still open.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (bus.nmi && !prev_nmi_q) begin
      win_cnt_d = VBLANK_LOAD;
    end else if (win_cnt_q != 12'd0) begin
      win_cnt_d = win_cnt_q - 12'd1;
    end
  end

  // Port 1 wins ties until it has taken BURST_MAX grants in a row over a waiting port 0.
  always_comb begin
    e0      = bus.r0_req;
    e1      = bus.r1_req && vblank_q;
    grant   = (state_q == IDLE) && (e0 || e1);
    grant1  = e1 && !(e0 && (burst_q == BURST_MAX));
    burst_d = burst_q;
    if (grant) begin
      if (grant1 && bus.r0_req && (burst_q != BURST_MAX)) begin
        burst_d = burst_q + 4'd1;
      end else if (!(grant1 && bus.r0_req)) begin
        burst_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_nmi_q <= 1'b0;
      win_cnt_q  <= 12'd0;
      vblank_q   <= 1'b0;
      gap_cnt_q  <= 4'd0;
      burst_q    <= 4'd0;
      win_id_q   <= 1'b0;
      addr_q     <= 3'd0;
      wdata_q    <= 8'd0;
      rw_q       <= 1'b0;
      cs_q       <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= 8'd0;
      rdata1_q   <= 8'd0;
    end else begin
      prev_nmi_q <= bus.nmi;
      win_cnt_q  <= win_cnt_d;
      vblank_q   <= (win_cnt_d != 12'd0);
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant) begin
            // The output registers double as the access latch for the cs-low cycle.
            state_q  <= ACCESS;
            cs_q     <= 1'b0;
            win_id_q <= grant1;
            burst_q  <= burst_d;
            if (grant1) begin
              addr_q  <= bus.r1_addr;
              rw_q    <= bus.r1_wr;
              wdata_q <= bus.r1_wr ? bus.r1_wdata : 8'd0;
            end else begin
              addr_q  <= bus.r0_addr;
              rw_q    <= bus.r0_wr;
              wdata_q <= bus.r0_wr ? bus.r0_wdata : 8'd0;
            end
          end
        end

        ACCESS: begin
          state_q   <= GAP;
          gap_cnt_q <= GAP_LOAD;
          cs_q      <= 1'b1;
          addr_q    <= 3'd0;
          wdata_q   <= 8'd0;
          rw_q      <= 1'b0;
          if (win_id_q) begin
            ack1_q <= 1'b1;
            if (!rw_q) rdata1_q <= bus.ppu_rdata;
          end else begin
            ack0_q <= 1'b1;
            if (!rw_q) rdata0_q <= bus.ppu_rdata;
          end
        end

        GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ppu_cs     = cs_q;
  assign bus.ppu_addr   = addr_q;
  assign bus.ppu_wdata  = wdata_q;
  assign bus.ppu_rw     = rw_q;
  assign bus.r0_ack     = ack0_q;
  assign bus.r1_ack     = ack1_q;
  assign bus.r0_rdata   = rdata0_q;
  assign bus.r1_rdata   = rdata1_q;
  assign bus.vblank_win = vblank_q;

endmodule

// File: tb/tb_ppu_bus_arbiter.sv
// Randomised and directed bench for ppu_bus_arbiter against a cycle-scheduled
// transaction model (grant times, window end time, expected ack cycles).
module tb_ppu_bus_arbiter;
  localparam int GAP = 1;
  localparam int VBL = 2273;
  localparam int R1B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppu_bus_arbiter_if bus();

  ppu_bus_arbiter #(
    .GAP_CYCLES   (GAP),
    .VBLANK_CYCLES(VBL),
    .R1_BURST     (R1B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Model: absolute cycle numbers at which things happen
  int cyc;
  int idle_from;
  int win_last;
  int acc_cycle;
  int acc_port;
  int acc_addr;
  int acc_wr;
  int acc_wdata;
  int burst_m;
  int nmi_prev_m;
  int rdata_m [2];

  // Observations for directed checks
  int ack_cnt [2];
  int vbl_cnt;
  int last_cs_cyc;
  int cs_gap;
  int order_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    idle_from  = cyc;
    win_last   = -1;
    acc_cycle  = -10;
    acc_port   = 0;
    acc_addr   = 0;
    acc_wr     = 0;
    acc_wdata  = 0;
    burst_m    = 0;
    nmi_prev_m = 0;
    rdata_m[0] = 0;
    rdata_m[1] = 0;
  endtask

  // Advance the model across the clock edge that starts cycle cyc, using the
  // inputs that were driven during cycle cyc-1.
  task automatic model_step();
    int e0;
    int e1;
    int pick1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (acc_cycle == cyc - 1 && acc_wr == 0) rdata_m[acc_port] = int'(bus.ppu_rdata);
    if (cyc - 1 >= idle_from) begin
      e0 = int'(bus.r0_req);
      e1 = (bus.r1_req && (cyc - 1 <= win_last)) ? 1 : 0;
      if (e0 != 0 || e1 != 0) begin
        pick1 = (e1 != 0 && !(e0 != 0 && burst_m == R1B)) ? 1 : 0;
        if (pick1 != 0 && bus.r0_req) burst_m = (burst_m < R1B) ? burst_m + 1 : R1B;
        else burst_m = 0;
        acc_cycle = cyc;
        acc_port  = pick1;
        acc_addr  = pick1 != 0 ? int'(bus.r1_addr)  : int'(bus.r0_addr);
        acc_wr    = pick1 != 0 ? int'(bus.r1_wr)    : int'(bus.r0_wr);
        acc_wdata = pick1 != 0 ? int'(bus.r1_wdata) : int'(bus.r0_wdata);
        idle_from = cyc + 1 + GAP;
      end
    end
    if (bus.nmi && nmi_prev_m == 0) win_last = cyc + VBL - 1;
    nmi_prev_m = int'(bus.nmi);
  endtask

  task automatic tick();
    bit cs_low;
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    cs_low = (acc_cycle == cyc);
    check_val("ppu_cs",     bus.ppu_cs,     cs_low ? 0 : 1);
    check_val("ppu_addr",   bus.ppu_addr,   cs_low ? acc_addr : 0);
    check_val("ppu_rw",     bus.ppu_rw,     cs_low ? acc_wr : 0);
    check_val("ppu_wdata",  bus.ppu_wdata,  (cs_low && acc_wr != 0) ? acc_wdata : 0);
    check_val("r0_ack",     bus.r0_ack,     (cyc == acc_cycle + 1 && acc_port == 0) ? 1 : 0);
    check_val("r1_ack",     bus.r1_ack,     (cyc == acc_cycle + 1 && acc_port == 1) ? 1 : 0);
    check_val("r0_rdata",   bus.r0_rdata,   rdata_m[0]);
    check_val("r1_rdata",   bus.r1_rdata,   rdata_m[1]);
    check_val("vblank_win", bus.vblank_win, (cyc <= win_last) ? 1 : 0);
    if (bus.r0_ack) begin ack_cnt[0]++; order_q.push_back(0); end
    if (bus.r1_ack) begin ack_cnt[1]++; order_q.push_back(1); end
    if (bus.vblank_win) vbl_cnt++;
    if (!bus.ppu_cs) begin
      cs_gap = cyc - last_cs_cyc;
      last_cs_cyc = cyc;
    end
  endtask

  task automatic set_req(input int p, input logic req, input logic [2:0] a,
                         input logic wr, input logic [7:0] d);
    if (p == 0) begin
      bus.r0_req = req; bus.r0_addr = a; bus.r0_wr = wr; bus.r0_wdata = d;
    end else begin
      bus.r1_req = req; bus.r1_addr = a; bus.r1_wr = wr; bus.r1_wdata = d;
    end
  endtask

  task automatic set_req_rand(input int p);
    set_req(p, 1'b1, 3'($urandom), 1'($urandom), 8'($urandom));
  endtask

  // Legal requester: fields only change while idle or in the ack cycle.
  task automatic req_policy(input int p, input int keep_pct, input int raise_pct);
    logic req;
    logic ack;
    req = (p == 0) ? bus.r0_req : bus.r1_req;
    ack = (p == 0) ? bus.r0_ack : bus.r1_ack;
    if (req && ack) begin
      if (int'($urandom_range(0, 99)) < keep_pct) set_req_rand(p);
      else set_req(p, 1'b0, 3'd0, 1'b0, 8'd0);
    end else if (!req && int'($urandom_range(0, 99)) < raise_pct) begin
      set_req_rand(p);
    end
  endtask

  task automatic wait_ack(input int p, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = (p == 0) ? bus.r0_ack : bus.r1_ack;
    end
    check_val(tag, 32'(got), 1);
  endtask

  task automatic do_reset();
    set_req(0, 1'b0, 3'd0, 1'b0, 8'd0);
    set_req(1, 1'b0, 3'd0, 1'b0, 8'd0);
    bus.nmi = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int a;
    int snap;
    bit found;
    int exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    bus.nmi = 1'b0;
    bus.ppu_rdata = 8'd0;
    set_req(0, 1'b0, 3'd0, 1'b0, 8'd0);
    set_req(1, 1'b0, 3'd0, 1'b0, 8'd0);
    cyc = 0;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    vbl_cnt = 0;
    last_cs_cyc = -100;
    cs_gap = 0;
    model_reset();

    // Reset, then idle with no requests
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Port 0 write, back-to-back
    set_req(0, 1'b1, 3'd5, 1'b1, 8'h28);
    wait_ack(0, "wr_ack1");
    wait_ack(0, "wr_ack2");
    check_val("cs_spacing", cs_gap, GAP + 2);
    set_req(0, 1'b0, 3'd0, 1'b0, 8'd0);
    repeat (3) tick();

    // Port 0 read
    bus.ppu_rdata = 8'h80;
    set_req(0, 1'b1, 3'd2, 1'b0, 8'd0);
    wait_ack(0, "rd_ack");
    check_val("rd_data", bus.r0_rdata, 8'h80);
    check_val("rd_r1_hold", bus.r1_rdata, 8'h00);
    set_req(0, 1'b0, 3'd0, 1'b0, 8'd0);
    repeat (3) tick();

    // Reset asserted during the cs-low cycle
    set_req(0, 1'b1, 3'd3, 1'b1, 8'h5a);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = !bus.ppu_cs;
    end
    check_val("rst_found_access", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_cs", bus.ppu_cs, 1);
    check_val("rst_async_ack", bus.r0_ack, 0);
    set_req(0, 1'b0, 3'd0, 1'b0, 8'd0);
    snap = ack_cnt[0];
    tick();
    tick();
    check_val("rst_no_ack", ack_cnt[0] - snap, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Port 1 without a window, then window length and last-cycle grant
    snap = ack_cnt[1];
    set_req_rand(1);
    repeat (60) tick();
    check_val("r1_no_window", ack_cnt[1] - snap, 0);
    vbl_cnt = 0;
    bus.nmi = 1'b1;
    a = cyc;
    tick();
    bus.nmi = 1'b0;
    wait_ack(1, "r1_win_ack");
    set_req(1, 1'b0, 3'd0, 1'b0, 8'd0);
    while (cyc < a + VBL) tick();
    set_req_rand(1);
    wait_ack(1, "r1_last_cycle_ack");
    while (cyc < a + VBL + 40) tick();
    check_val("window_len", vbl_cnt, VBL);
    check_val("r1_win_acks", ack_cnt[1] - snap, 2);
    set_req(1, 1'b0, 3'd0, 1'b0, 8'd0);

    // Both held inside the window: burst-limited grant order
    do_reset();
    repeat (2) tick();
    bus.nmi = 1'b1;
    tick();
    bus.nmi = 1'b0;
    order_q.delete();
    set_req_rand(0);
    set_req_rand(1);
    for (int i = 0; i < 100 && order_q.size() < 10; i++) begin
      tick();
      if (bus.r0_ack) set_req_rand(0);
      if (bus.r1_ack) set_req_rand(1);
    end
    check_val("order_len", order_q.size() >= 10 ? 10 : order_q.size(), 10);
    for (int i = 0; i < 10 && i < order_q.size(); i++) begin
      check_val($sformatf("order_%0d", i), order_q[i], exp_order[i]);
    end

    // Window reload by a second edge; held-high nmi gives no further reload
    do_reset();
    repeat (2) tick();
    vbl_cnt = 0;
    bus.nmi = 1'b1;
    a = cyc;
    tick();
    bus.nmi = 1'b0;
    while (cyc < a + 1000) begin
      tick();
      req_policy(0, 50, 20);
      req_policy(1, 50, 20);
    end
    bus.nmi = 1'b1;
    while (cyc < a + 1000 + VBL + 30) begin
      tick();
      req_policy(0, 50, 20);
      req_policy(1, 50, 20);
    end
    bus.nmi = 1'b0;
    check_val("reload_len", vbl_cnt, 1000 + VBL);

    // Free-running random traffic with sporadic NMI edges
    bus.nmi = 1'b1;
    tick();
    for (int i = 0; i < 4000; i++) begin
      bus.nmi = ($urandom_range(0, 1499) == 0);
      bus.ppu_rdata = 8'($urandom);
      req_policy(0, 50, 30);
      req_policy(1, 50, 30);
      tick();
    end
    check_val("rand_r0_served", 32'(ack_cnt[0] > 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
